fifo_sync_fwft: RTL

//  Single-clock, parametrised FIFO; successor to the fixed 32-bit, 256-deep block-RAM FIFO.

---
 rtl/fifo_sync_fwft_pkg.sv | 26 ++
 rtl/fifo_sync_fwft_ram_sdp.sv | 34 +++
 rtl/fifo_sync_fwft.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_fwft_pkg.sv
// Shared definitions for the single-clock first-word-fall-through FIFO.
// Holds the default geometry, the address-width helper and the
// output-source selector used by the top level.
package fifo_sync_fwft_pkg;

  // Default geometry (the classic 32-bit, 256-deep configuration).
  localparam int FIFO_DEFAULT_WIDTH = 32;
  localparam int FIFO_DEFAULT_DEPTH = 256;

  // Where the word presented on o_rdData comes from.
  //   SRC_ZERO   : nothing has been read since reset/flush, show zero
  //   SRC_RAM    : the registered read port of the storage RAM
  //   SRC_BYPASS : a word captured directly from the write side while the
  //                head was popped and the RAM was empty (count stays 1)
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_RAM    = 2'd1,
    SRC_BYPASS = 2'd2
  } outSrc_e;

  // Address width for a given (power-of-two) depth.
  function automatic int fifoAddrW(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync_fwft_ram_sdp.sv
// Simple dual-port storage RAM: one write port, one registered read port.
// No reset on the array or the read register so the tools can map it onto
// block RAM (ice40 SB_RAM) by inference.
module fifo_sync_fwft_ram_sdp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]  wrData_i,
  input  logic              rdEn_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [WIDTH-1:0]  rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  // Write port and registered read port; the read register only moves when
  // asked to, so the last word read stays on rdData_o otherwise.
  always_ff @(posedge clock_i) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    if (rdEn_i) begin
      rdData_q <= mem[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock parametrised FIFO with valid/ready handshakes on both sides,
// first-word-fall-through output, occupancy count, almost-full/almost-empty
// flags and a synchronous flush.
//
// The RAM's registered read port doubles as the output (prefetch) register:
// a word written into an empty FIFO is read out on the following edge and is
// then visible on o_rdData. The only exception is a push and a pop in the
// same cycle while the RAM holds nothing behind the head: the incoming word
// is captured straight into a bypass register so a steady one-word stream
// flows at one word per clock with no bubble.
module fifo_sync_fwft
  import fifo_sync_fwft_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                        i_clock,
  input  logic                        i_nReset,
  input  logic                        i_flush,
  input  logic [WIDTH-1:0]            i_wrData,
  input  logic                        i_wrValid,
  output logic                        o_wrReady,
  output logic [WIDTH-1:0]            o_rdData,
  output logic                        o_rdValid,
  input  logic                        i_rdReady,
  output logic [fifoAddrW(DEPTH):0]   o_count,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_almostFull,
  output logic                        o_almostEmpty
);

  localparam int ADDR_W = fifoAddrW(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Pointers carry one extra bit so a full RAM and an empty RAM differ.
  logic [CNT_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             rdValid_q, rdValid_d;
  outSrc_e          src_q, src_d;
  logic [WIDTH-1:0] bypData_q, bypData_d;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic almostFull_q, almostFull_d;
  logic almostEmpty_q, almostEmpty_d;

  logic             ramEmpty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             ramWrEn;
  logic             ramRdEn;
  logic [WIDTH-1:0] ramRdData;

  // Handshake decode. The RAM holds the words behind the head; it is empty
  // when both pointers match. A flush cancels any write or read this cycle.
  assign ramEmpty  = (wrPtr_q == rdPtr_q);
  assign o_wrReady = !full_q;
  assign push      = i_wrValid & !full_q;
  assign pop       = rdValid_q & i_rdReady;
  assign bypass    = push & pop & ramEmpty;
  assign ramWrEn   = push & !bypass & !i_flush;
  assign ramRdEn   = !ramEmpty & (!rdValid_q | pop) & !i_flush;

  fifo_sync_fwft_ram_sdp #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock_i  (i_clock),
    .wrEn_i   (ramWrEn),
    .wrAddr_i (wrPtr_q[ADDR_W-1:0]),
    .wrData_i (i_wrData),
    .rdEn_i   (ramRdEn),
    .rdAddr_i (rdPtr_q[ADDR_W-1:0]),
    .rdData_o (ramRdData)
  );

  // Next-state for pointers, occupancy and the head word; flush wins over all.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    rdValid_d = rdValid_q;
    src_d     = src_q;
    bypData_d = bypData_q;
    if (i_flush) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
      rdValid_d = 1'b0;
      src_d     = SRC_ZERO;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (ramWrEn) begin
        wrPtr_d = wrPtr_q + CNT_ONE;
      end
      if (ramRdEn) begin
        rdPtr_d   = rdPtr_q + CNT_ONE;
        rdValid_d = 1'b1;
        src_d     = SRC_RAM;
      end else if (bypass) begin
        bypData_d = i_wrData;
        rdValid_d = 1'b1;
        src_d     = SRC_BYPASS;
      end else if (pop) begin
        rdValid_d = 1'b0;
      end
    end
  end

  // Status flags are derived from the next count so they change on the
  // same edge as the count itself.
  always_comb begin
    full_d        = (count_d == DEPTH_CNT);
    empty_d       = (count_d == '0);
    almostFull_d  = (count_d >= AF_CNT);
    almostEmpty_d = (count_d <= AE_CNT);
  end

  // State registers: asynchronous assert of reset, released on the clock.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      rdValid_q     <= 1'b0;
      src_q         <= SRC_ZERO;
      bypData_q     <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      rdValid_q     <= rdValid_d;
      src_q         <= src_d;
      bypData_q     <= bypData_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
    end
  end

  // Head-word select; each source only changes when a new head is loaded,
  // so the word holds while the consumer stalls and after the last pop.
  always_comb begin
    o_rdData = '0;
    case (src_q)
      SRC_RAM:    o_rdData = ramRdData;
      SRC_BYPASS: o_rdData = bypData_q;
      default:    o_rdData = '0;
    endcase
  end

  assign o_rdValid     = rdValid_q;
  assign o_count       = count_q;
  assign o_full        = full_q;
  assign o_empty       = empty_q;
  assign o_almostFull  = almostFull_q;
  assign o_almostEmpty = almostEmpty_q;

endmodule
